// File: rtl/snn_step_sequencer.sv
// snn_step_sequencer: per-sample controller for the LIF SNN core (clear, gated frames, spike
// counting, serial argmax). Optional idle-frame watchdog enabled by SNN_STEP_SEQ_TIMEOUT_EN.
module snn_step_sequencer #(
    parameter int F           = 48,
    parameter int N           = 96,
    parameter int T_STEPS     = 32,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    output logic                 busy,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    input  logic [F-1:0]         frame_data,
    output logic                 core_clear,
    output logic                 core_step,
    output logic [F-1:0]         core_event_vec,
    input  logic [N-1:0]         core_spikes_vec,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [$clog2(N)-1:0] result_class,
    output logic [CNT_W-1:0]     result_count,
    output logic                 timeout_err
);

    localparam int IDX_W  = $clog2(N);
    localparam int STEP_W = $clog2(T_STEPS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (N < 2 || T_STEPS < 1 || CNT_W < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("snn_step_sequencer: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_REDUCE,
        S_OUT
    } state_t;

    state_t               state_reg;
    logic                 busy_reg;
    logic                 frame_ready_reg;
    logic                 core_clear_reg;
    logic                 result_valid_reg;
    logic [IDX_W-1:0]     result_class_reg;
    logic [CNT_W-1:0]     result_count_reg;
    logic [STEP_W-1:0]    step_cnt_reg;
    logic                 step_d_reg;
    logic [IDX_W-1:0]     red_idx_reg;
    logic [IDX_W-1:0]     best_idx_reg;
    logic [CNT_W-1:0]     best_cnt_reg;

    logic                 accept;
    logic [N*CNT_W-1:0]   cnt_flat;
    logic [CNT_W-1:0]     cur_cnt;
    logic                 take;
    logic [IDX_W-1:0]     cand_idx;
    logic [CNT_W-1:0]     cand_cnt;

    // frame_ready_reg is high exactly while in RUN, so it doubles as the state gate.
    assign accept         = frame_ready_reg & frame_valid;
    assign core_step      = accept;
    assign core_event_vec = accept ? frame_data : '0;

    assign busy         = busy_reg;
    assign frame_ready  = frame_ready_reg;
    assign core_clear   = core_clear_reg;
    assign result_valid = result_valid_reg;
    assign result_class = result_class_reg;
    assign result_count = result_count_reg;

`ifdef SNN_STEP_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_reg;
    logic            timeout_err_reg;
    assign timeout_err = timeout_err_reg;
`else
    assign timeout_err = 1'b0;
`endif

    // Per-neuron saturating spike counters; core spikes are valid the cycle after a step.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    cnt_reg <= '0;
                end else if (state_reg == S_CLEAR) begin
                    cnt_reg <= '0;
                end else if (step_d_reg && core_spikes_vec[gi] && (cnt_reg != CNT_MAX)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate

    // Strictly-greater replacement keeps the lowest index on ties.
    assign cur_cnt  = cnt_flat[int'(red_idx_reg)*CNT_W +: CNT_W];
    assign take     = cur_cnt > best_cnt_reg;
    assign cand_idx = take ? red_idx_reg : best_idx_reg;
    assign cand_cnt = take ? cur_cnt : best_cnt_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg        <= S_IDLE;
            busy_reg         <= 1'b0;
            frame_ready_reg  <= 1'b0;
            core_clear_reg   <= 1'b0;
            result_valid_reg <= 1'b0;
            result_class_reg <= '0;
            result_count_reg <= '0;
            step_cnt_reg     <= '0;
            step_d_reg       <= 1'b0;
            red_idx_reg      <= '0;
            best_idx_reg     <= '0;
            best_cnt_reg     <= '0;
`ifdef SNN_STEP_SEQ_TIMEOUT_EN
            wd_reg           <= '0;
            timeout_err_reg  <= 1'b0;
`endif
        end else begin
            step_d_reg     <= accept;
            core_clear_reg <= 1'b0;
            unique case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg      <= S_CLEAR;
                        busy_reg       <= 1'b1;
                        core_clear_reg <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_reg       <= S_RUN;
                    frame_ready_reg <= 1'b1;
                    step_cnt_reg    <= '0;
`ifdef SNN_STEP_SEQ_TIMEOUT_EN
                    wd_reg          <= '0;
`endif
                end
                S_RUN: begin
                    if (accept) begin
                        step_cnt_reg <= step_cnt_reg + 1'b1;
`ifdef SNN_STEP_SEQ_TIMEOUT_EN
                        wd_reg       <= '0;
`endif
                        if (step_cnt_reg == STEP_W'(T_STEPS - 1)) begin
                            state_reg       <= S_DRAIN;
                            frame_ready_reg <= 1'b0;
                        end
                    end
`ifdef SNN_STEP_SEQ_TIMEOUT_EN
                    else if (wd_reg == WD_W'(TIMEOUT_CYC - 1)) begin
                        // Abort without a result; partial counts are wiped by the next CLEAR.
                        timeout_err_reg <= 1'b1;
                        state_reg       <= S_IDLE;
                        frame_ready_reg <= 1'b0;
                        busy_reg        <= 1'b0;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
`endif
                end
                S_DRAIN: begin
                    state_reg    <= S_REDUCE;
                    red_idx_reg  <= '0;
                    best_idx_reg <= '0;
                    best_cnt_reg <= '0;
                end
                S_REDUCE: begin
                    best_idx_reg <= cand_idx;
                    best_cnt_reg <= cand_cnt;
                    red_idx_reg  <= red_idx_reg + 1'b1;
                    if (red_idx_reg == IDX_W'(N - 1)) begin
                        result_class_reg <= cand_idx;
                        result_count_reg <= cand_cnt;
                        result_valid_reg <= 1'b1;
                        state_reg        <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (result_ready) begin
                        result_valid_reg <= 1'b0;
                        busy_reg         <= 1'b0;
                        state_reg        <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_step_sequencer.sv
// Scoreboard bench for snn_step_sequencer: two instances (short-T and saturating-counter builds)
// share the stimulus through a select; a simple core model echoes event bits as spikes.
module tb_snn_step_sequencer;

    localparam int F    = 8;
    localparam int N    = 4;
    localparam int T_A  = 3;
    localparam int CW_A = 8;
    localparam int T_B  = 8;
    localparam int CW_B = 3;
    localparam int TO   = 16;

    typedef struct {
        int cls;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic         sel = 1'b0;
    logic         start = 1'b0;
    logic         frame_valid = 1'b0;
    logic         result_ready = 1'b0;
    logic [F-1:0] frame_data = '0;

    logic busy_a, fr_a, clr_a, step_a, rv_a, to_a;
    logic busy_b, fr_b, clr_b, step_b, rv_b, to_b;
    logic [F-1:0] ev_a, ev_b;
    logic [1:0] cls_a, cls_b;
    logic [CW_A-1:0] cnt_a;
    logic [CW_B-1:0] cnt_b;
    logic [N-1:0] spk_a = '0;
    logic [N-1:0] spk_b = '0;

    snn_step_sequencer #(.F(F), .N(N), .T_STEPS(T_A), .CNT_W(CW_A), .TIMEOUT_CYC(TO)) dut_a (
        .clk(clk), .rstn(rstn), .start(start & ~sel), .busy(busy_a),
        .frame_valid(frame_valid & ~sel), .frame_ready(fr_a), .frame_data(frame_data),
        .core_clear(clr_a), .core_step(step_a), .core_event_vec(ev_a), .core_spikes_vec(spk_a),
        .result_valid(rv_a), .result_ready(result_ready & ~sel), .result_class(cls_a),
        .result_count(cnt_a), .timeout_err(to_a)
    );

    snn_step_sequencer #(.F(F), .N(N), .T_STEPS(T_B), .CNT_W(CW_B), .TIMEOUT_CYC(TO)) dut_b (
        .clk(clk), .rstn(rstn), .start(start & sel), .busy(busy_b),
        .frame_valid(frame_valid & sel), .frame_ready(fr_b), .frame_data(frame_data),
        .core_clear(clr_b), .core_step(step_b), .core_event_vec(ev_b), .core_spikes_vec(spk_b),
        .result_valid(rv_b), .result_ready(result_ready & sel), .result_class(cls_b),
        .result_count(cnt_b), .timeout_err(to_b)
    );

    // Core model: spikes registered on the step edge, garbage otherwise.
    always @(posedge clk) spk_a <= step_a ? ev_a[N-1:0] : N'($urandom);
    always @(posedge clk) spk_b <= step_b ? ev_b[N-1:0] : N'($urandom);

    logic busy, frame_ready, core_clear, core_step, result_valid, timeout_err;
    logic [F-1:0] core_event_vec;
    logic [1:0] result_class;
    logic [7:0] result_count;
    assign busy           = sel ? busy_b : busy_a;
    assign frame_ready    = sel ? fr_b : fr_a;
    assign core_clear     = sel ? clr_b : clr_a;
    assign core_step      = sel ? step_b : step_a;
    assign core_event_vec = sel ? ev_b : ev_a;
    assign result_valid   = sel ? rv_b : rv_a;
    assign result_class   = sel ? cls_b : cls_a;
    assign result_count   = sel ? {5'd0, cnt_b} : cnt_a;
    assign timeout_err    = sel ? to_b : to_a;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   step_pulses = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [N-1:0] pat [0:7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            check_eq("clr_vs_step", 32'(core_clear & core_step), 0);
            check_eq("step_hs", 32'(core_step), 32'(frame_valid & frame_ready));
            check_eq("evt_vec", 32'(core_event_vec), core_step ? 32'(frame_data) : 0);
            if (core_step) step_pulses++;
            if (result_valid && result_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_empty", 0, 1);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("res_class", 32'(result_class), mon_e.cls);
                    check_eq("res_count", 32'(result_count), mon_e.cnt);
                    $display("result: class %0d count %0d", result_class, result_count);
                end
            end
        end
    end

    task automatic check_reset();
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_frame_ready", 32'(frame_ready), 0);
        check_eq("rst_core_clear", 32'(core_clear), 0);
        check_eq("rst_core_step", 32'(core_step), 0);
        check_eq("rst_event_vec", 32'(core_event_vec), 0);
        check_eq("rst_result_valid", 32'(result_valid), 0);
        check_eq("rst_result_class", 32'(result_class), 0);
        check_eq("rst_result_count", 32'(result_count), 0);
        check_eq("rst_timeout_err", 32'(timeout_err), 0);
    endtask

    task automatic run_sample(input int t, input int cmax, input int gap, input int hold,
                              input int stall_k, input int stall);
        int   c [N];
        int   best, bi, c0, w;
        exp_t e;
        for (int n = 0; n < N; n++) begin
            c[n] = 0;
            for (int k = 0; k < t; k++)
                if (pat[k][n] && c[n] < cmax) c[n]++;
        end
        best = 0;
        bi   = 0;
        for (int n = 0; n < N; n++)
            if (c[n] > best) begin
                best = c[n];
                bi   = n;
            end
        e.cls = bi;
        e.cnt = best;
        sb.push_back(e);

        step_pulses = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
        check_eq("clear_pulse", 32'(core_clear), 1);
        check_eq("clear_ready", 32'(frame_ready), 0);
        check_eq("clear_busy", 32'(busy), 1);
        tick();
        check_eq("clear_end", 32'(core_clear), 0);
        check_eq("run_ready", 32'(frame_ready), 1);
        for (int k = 0; k < t; k++) begin
            if (k > 0) begin
                for (int g = 0; g < gap; g++) begin
                    frame_valid = 1'b0;
                    frame_data  = F'($urandom);
                    tick();
                end
            end
            if (k == stall_k && stall > 0) begin
                frame_valid = 1'b0;
                repeat (stall) tick();
                check_eq("stall_timeout_err", 32'(timeout_err), 0);
                check_eq("stall_busy", 32'(busy), 1);
            end
            frame_valid = 1'b1;
            frame_data  = {4'($urandom), pat[k]};
            tick();
        end
        frame_valid = 1'b0;
        frame_data  = F'($urandom);
        w = 0;
        while (!result_valid && w < 300) begin
            tick();
            w++;
        end
        if (!result_valid) begin
            check_eq("result_wait", 0, 1);
            return;
        end
        check_eq("latency", cyc - c0, t + N + 2 + gap * (t - 1) + stall);
        for (int h = 0; h < hold; h++) begin
            check_eq("hold_valid", 32'(result_valid), 1);
            if (sb.size() > 0) begin
                check_eq("hold_class", 32'(result_class), sb[0].cls);
                check_eq("hold_count", 32'(result_count), sb[0].cnt);
            end
            start = (h == 3);
            tick();
        end
        start = 1'b0;
        check_eq("out_busy", 32'(busy), 1);
        result_ready = 1'b1;
        start = 1'b1;
        tick();
        result_ready = 1'b0;
        start = 1'b0;
        check_eq("done_valid", 32'(result_valid), 0);
        check_eq("done_busy", 32'(busy), 0);
        tick();
        check_eq("late_start_ignored", 32'(busy | core_clear), 0);
        check_eq("step_pulses", step_pulses, t);
    endtask

    initial begin
        #12;
        check_reset();
        tick();
        rstn = 1'b1;
        tick();
        tick();
        check_reset();

        // Neuron 2 spikes on all steps, neuron 1 on two: class 2, count 3.
        sel = 1'b0;
        pat[0] = 4'b0110;
        pat[1] = 4'b0100;
        pat[2] = 4'b0110;
        run_sample(T_A, 255, 0, 0, -1, 0);
        run_sample(T_A, 255, 2, 0, -1, 0);
        run_sample(T_A, 255, 0, 10, -1, 0);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) pat[k] = N'($urandom);
            run_sample(T_A, 255, r, 2, -1, 0);
        end
`ifndef SNN_STEP_SEQ_TIMEOUT_EN
        run_sample(T_A, 255, 0, 0, 1, 40);
`endif

        // Reset in the middle of RUN with a frame still offered.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        frame_valid = 1'b1;
        frame_data  = 8'h0F;
        tick();
        #2;
        rstn = 1'b0;
        #1;
        check_reset();
        tick();
        tick();
        rstn = 1'b1;
        frame_valid = 1'b0;
        tick();
        check_eq("post_rst_busy", 32'(busy), 0);
        check_eq("post_rst_valid", 32'(result_valid), 0);

        sel = 1'b1;
        tick();
        // Tie: neurons 1 and 3 both reach 5 -> lowest index wins.
        for (int k = 0; k < 8; k++)
            pat[k] = {4'(k >= 3), 4'(k < 2), 4'(k < 5), 4'(k % 2 == 0)} == 16'h0 ? '0 :
                     {(k >= 3) ? 1'b1 : 1'b0, (k < 2) ? 1'b1 : 1'b0,
                      (k < 5) ? 1'b1 : 1'b0, (k % 2 == 0) ? 1'b1 : 1'b0};
        run_sample(T_B, 7, 0, 0, -1, 0);
        // Saturation: neuron 0 sees 8 spikes and neuron 2 sees 7; both clamp to 7.
        for (int k = 0; k < 8; k++)
            pat[k] = {(k < 6) ? 1'b1 : 1'b0, (k < 7) ? 1'b1 : 1'b0, 1'b0, 1'b1};
        run_sample(T_B, 7, 1, 0, -1, 0);
        for (int k = 0; k < 8; k++) pat[k] = '0;
        run_sample(T_B, 7, 0, 0, -1, 0);
        for (int k = 0; k < 8; k++) pat[k] = N'($urandom);
        run_sample(T_B, 7, 0, 3, -1, 0);

`ifdef SNN_STEP_SEQ_TIMEOUT_EN
        sel = 1'b0;
        tick();
        sb.push_back('{cls: -1, cnt: -1});
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        frame_valid = 1'b1;
        frame_data  = 8'h01;
        tick();
        frame_valid = 1'b0;
        repeat (TO - 1) tick();
        check_eq("wd_pre_err", 32'(timeout_err), 0);
        check_eq("wd_pre_busy", 32'(busy), 1);
        tick();
        check_eq("wd_err", 32'(timeout_err), 1);
        check_eq("wd_busy", 32'(busy), 0);
        check_eq("wd_ready", 32'(frame_ready), 0);
        repeat (5) tick();
        check_eq("wd_no_result", 32'(result_valid), 0);
        check_eq("wd_sticky", 32'(timeout_err), 1);
        void'(sb.pop_back());
`endif

        check_eq("sb_left", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/snn_step_sequencer.md
Name: snn_step_sequencer

Overview:
Sample-level controller for the LIF SNN core. Accepts one start per sample and clears the core state. It then gates exactly T_STEPS input event frames into the core, one timestep per accepted frame. It accumulates per-neuron spike counts, then serially reduces them to a winning class index that is presented on a valid/ready result port.

Parameters:
F, 48, event-vector width (input features)
N, 96, neuron count (classes)
T_STEPS, 32, timesteps per sample (>=1)
CNT_W, 8, per-neuron spike-counter width (saturating)
TIMEOUT_CYC, 1024, idle-frame watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
start  in  1  begin a sample; one-cycle pulse; ignored unless in IDLE
busy  out  1  high in every state except IDLE
frame_valid  in  1  input event frame available
frame_ready  out  1  sequencer accepts a frame this cycle
frame_data  in  F  event bits for one timestep
core_clear  out  1  one-cycle pulse; core must zero V and refractory counters
core_step  out  1  core advances one timestep this cycle
core_event_vec  out  F  event vector to the core; equals frame_data when core_step=1, else 0
core_spikes_vec  in  N  core spike output, registered by the core on the step edge
result_valid  out  1  result available
result_ready  in  1  consumer accepts result
result_class  out  $clog2(N)  winning neuron index
result_count  out  CNT_W  spike count of the winner
timeout_err  out  1  sticky error flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset values: busy=0, frame_ready=0, core_clear=0, core_step=0, core_event_vec=0, result_valid=0, result_class=0, result_count=0, timeout_err=0. The state register goes to IDLE and all counters clear.
- States: IDLE, CLEAR, RUN, DRAIN, REDUCE, OUT.
- IDLE: when start=1, go to CLEAR.
- CLEAR (1 cycle):
  - core_clear=1.
  - All N spike counters reset to 0; step counter reset to 0.
  - Next state is RUN.
- RUN:
  - frame_ready=1.
  - A frame is accepted on frame_valid&frame_ready. In that cycle core_step=1 (combinational), core_event_vec=frame_data, and the step counter increments.
  - On the accepting cycle for step T_STEPS-1, go to DRAIN.
  - No frame_valid means no step and no count change; the sequencer waits indefinitely (no watchdog without the feature).
- Spike accumulation:
  - An internal 1-cycle-delayed copy of core_step (step_d) marks core_spikes_vec as valid for the preceding step.
  - When step_d=1, each counter[n] increments if core_spikes_vec[n]=1.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - Back-to-back steps accumulate every cycle with no bubbles.
- DRAIN (1 cycle): absorbs the spikes of the final step via step_d, then goes to REDUCE.
- REDUCE (N cycles):
  - Index i runs 0..N-1, one neuron per cycle.
  - The best candidate is replaced only on strictly greater count, so ties resolve to the lowest index.
  - If all counts are 0, the winner is class 0 with count 0.
  - After i=N-1, latch result_class and result_count, then go to OUT.
- OUT:
  - result_valid=1; result_class and result_count are stable while result_valid=1 and result_ready=0.
  - On result_ready=1, go to IDLE and deassert result_valid on the next cycle.
- Latency with back-to-back frames: start to result_valid = 1 (CLEAR) + T_STEPS + 1 (DRAIN) + N (REDUCE) cycles.
- Simultaneous events:
  - start while busy is ignored.
  - start in the same cycle that OUT completes is ignored; a new start is required in IDLE.
- Reset mid-operation returns to IDLE immediately with all outputs at reset values. Core state is not cleared by this block on reset; the core shares rstn.
- core_clear and core_step are never high in the same cycle.

Optional Feature:
Macro SNN_STEP_SEQ_TIMEOUT_EN.
- Defined:
  - In RUN, a watchdog counts consecutive cycles with frame_valid=0 and resets on any accepted frame.
  - When the count reaches TIMEOUT_CYC, timeout_err is set (sticky until rstn), the sample aborts, and the sequencer goes directly to IDLE with no result.
  - Partial spike counts are discarded.
- Not defined: no watchdog logic is present; timeout_err=0 constantly; RUN waits forever.

Test Plan:
- Reset then idle: check every output at its reset value; start pulse -> core_clear high exactly 1 cycle, then frame_ready=1.
- N=4, T_STEPS=3, frames every cycle; core model spikes neuron 2 on all steps and neuron 1 on 2 steps -> result_class=2, result_count=3, start-to-valid = 1+3+1+4 = 9 cycles.
- Gapped frame_valid (1 cycle on, 2 off) -> exactly T_STEPS core_step pulses; core_event_vec=0 during gaps; counts identical to the back-to-back run.
- Tie case: neurons 1 and 3 both have count 5 -> result_class=1. CNT_W=2 with 6 spikes on neuron 0 -> result_count=3 (saturated).
- Hold result_ready=0 for 10 cycles -> result stable with result_valid high; start pulses during that window are ignored. Assert result_ready -> IDLE, then a new start works.
- rstn asserted mid-RUN -> immediate IDLE and outputs at reset values. With SNN_STEP_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16, stall frames for 16 cycles -> timeout_err=1, busy=0, no result_valid.
